// File: rtl/irq_request_latch_pkg.sv
// Shared defaults and types for the interrupt request capture stage.
package irq_pkg;

    localparam int unsigned DEF_N           = 4;
    localparam int unsigned DEF_IDX_W       = 2;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam bit          DEF_EDGE_MODE   = 1'b1;

    typedef logic [DEF_N-1:0] req_vec_t;

endpackage

// File: rtl/irq_request_latch_if.sv
// Control/status bus between the request latch and its consumer (encoder + software).
interface irq_request_latch_if #(
    parameter int unsigned N     = irq_pkg::DEF_N,
    parameter int unsigned IDX_W = irq_pkg::DEF_IDX_W
);

    logic             mask_wr;
    logic [N-1:0]     mask_din;
    logic             ack;
    logic [IDX_W-1:0] ack_idx;
    logic             clr_ovf;
    logic [N-1:0]     pend_out;
    logic [N-1:0]     pend_raw;
    logic             irq;
    logic [N-1:0]     ovf;
    logic             ack_err;

    modport master (
        output mask_wr, mask_din, ack, ack_idx, clr_ovf,
        input  pend_out, pend_raw, irq, ovf, ack_err
    );

    modport slave (
        input  mask_wr, mask_din, ack, ack_idx, clr_ovf,
        output pend_out, pend_raw, irq, ovf, ack_err
    );

endinterface

// File: rtl/irq_request_latch_sync_edge_det.sv
// One request line: multi-flop synchroniser followed by an edge-history flop.
module sync_edge_det
    import irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter bit          EDGE_MODE   = DEF_EDGE_MODE
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic ev
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    always_comb begin
        lvl = sync_q[SYNC_STAGES-1];
        ev  = EDGE_MODE ? (lvl & ~hist_q) : lvl;
    end

endmodule

// File: rtl/irq_request_latch.sv
// Captures request events into sticky pending bits, masks them for the encoder,
// and handles acknowledge, overflow and ack-error reporting.
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int unsigned N           = DEF_N,
    parameter int unsigned IDX_W       = DEF_IDX_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter bit          EDGE_MODE   = DEF_EDGE_MODE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_in,
    irq_request_latch_if.slave  bus
);

    logic [N-1:0] line_lvl;
    logic [N-1:0] line_edge;
    logic [N-1:0] ev;

    for (genvar g = 0; g < N; g++) begin : g_line
        sync_edge_det #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (req_in[g]),
            .lvl (line_lvl[g]),
            .ev  (line_edge[g])
        );
    end

    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] ovf_q, ovf_d;
    logic         ack_err_q, ack_err_d;

    logic [N-1:0] ack_hit;
    logic [N-1:0] clr_hit;
    logic [N-1:0] set_win;
    logic [N-1:0] ovf_set;

    always_comb begin
        ev = EDGE_MODE ? line_edge : line_lvl;

        ack_hit = '0;
        for (int unsigned i = 0; i < N; i++) begin
            ack_hit[i] = bus.ack && (bus.ack_idx == IDX_W'(i));
        end
        clr_hit = ack_hit & pend_q;

        // Edge mode: a new event beats a same-cycle ack. Level mode: the ack
        // wins so the line can drop for one cycle before re-setting.
        if (EDGE_MODE) begin
            set_win = ev;
            ovf_set = ev & pend_q & ~ack_hit;
        end else begin
            set_win = ev & ~clr_hit;
            ovf_set = '0;
        end

        pend_d    = set_win | (pend_q & ~clr_hit);
        ovf_d     = (bus.clr_ovf ? '0 : ovf_q) | ovf_set;
        mask_d    = bus.mask_wr ? bus.mask_din : mask_q;
        // Out-of-range indices never hit, so they fall into the error path too.
        ack_err_d = bus.ack & ~(|clr_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            mask_q    <= '1;
            ovf_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            ovf_q     <= ovf_d;
            ack_err_q <= ack_err_d;
        end
    end

    always_comb begin
        bus.pend_raw = pend_q;
        bus.pend_out = pend_q & mask_q;
        bus.irq      = |(pend_q & mask_q);
        bus.ovf      = ovf_q;
        bus.ack_err  = ack_err_q;
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Bench for irq_request_latch: edge- and level-mode instances share stimulus and
// are compared every cycle against a delay-line reference model.
module tb_irq_request_latch;
    import irq_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned SYNC  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    req_vec_t         req_in;
    logic             mask_wr;
    logic [N-1:0]     mask_din;
    logic             ack;
    logic [IDX_W-1:0] ack_idx;
    logic             clr_ovf;

    irq_request_latch_if #(.N(N), .IDX_W(IDX_W)) bus_e ();
    irq_request_latch_if #(.N(N), .IDX_W(IDX_W)) bus_l ();

    assign bus_e.mask_wr  = mask_wr;
    assign bus_e.mask_din = mask_din;
    assign bus_e.ack      = ack;
    assign bus_e.ack_idx  = ack_idx;
    assign bus_e.clr_ovf  = clr_ovf;
    assign bus_l.mask_wr  = mask_wr;
    assign bus_l.mask_din = mask_din;
    assign bus_l.ack      = ack;
    assign bus_l.ack_idx  = ack_idx;
    assign bus_l.clr_ovf  = clr_ovf;

    irq_request_latch #(.N(N), .IDX_W(IDX_W), .SYNC_STAGES(SYNC), .EDGE_MODE(1'b1)) dut_e (
        .clk    (clk),
        .rst    (rst),
        .req_in (req_in),
        .bus    (bus_e)
    );

    irq_request_latch #(.N(N), .IDX_W(IDX_W), .SYNC_STAGES(SYNC), .EDGE_MODE(1'b0)) dut_l (
        .clk    (clk),
        .rst    (rst),
        .req_in (req_in),
        .bus    (bus_l)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samp[j] holds req_in sampled j+1 edges ago (index 0 newest).
    // Index 0 of the per-instance arrays is the level-mode DUT, index 1 edge mode.
    logic [3:0] samp [0:SYNC];
    logic [3:0] m_pend [2];
    logic [3:0] m_mask [2];
    logic [3:0] m_ovf  [2];
    logic       m_err  [2];

    always @(posedge clk) begin : model
        logic [3:0] s, p, pn, on;
        logic       ev, hit;
        if (rst) begin
            for (int j = 0; j <= SYNC; j++) samp[j] <= 4'h0;
            for (int m = 0; m < 2; m++) begin
                m_pend[m] <= 4'h0;
                m_mask[m] <= 4'hF;
                m_ovf[m]  <= 4'h0;
                m_err[m]  <= 1'b0;
            end
        end else begin
            s = samp[SYNC-1];
            p = samp[SYNC];
            for (int m = 0; m < 2; m++) begin
                pn = m_pend[m];
                on = clr_ovf ? 4'h0 : m_ovf[m];
                for (int i = 0; i < 4; i++) begin
                    ev  = (m == 1) ? (s[i] & ~p[i]) : s[i];
                    hit = ack && (int'(ack_idx) == i);
                    if (m == 1) begin
                        if (ev) begin
                            if (m_pend[m][i] && !hit) on[i] = 1'b1;
                            pn[i] = 1'b1;
                        end else if (hit) begin
                            pn[i] = 1'b0;
                        end
                    end else begin
                        if (hit && m_pend[m][i]) pn[i] = 1'b0;
                        else if (ev)             pn[i] = 1'b1;
                    end
                end
                m_err[m]  <= ack && !m_pend[m][ack_idx];
                m_pend[m] <= pn;
                m_ovf[m]  <= on;
                if (mask_wr) m_mask[m] <= mask_din;
            end
            for (int j = SYNC; j > 0; j--) samp[j] <= samp[j-1];
            samp[0] <= req_in;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("E pend_raw", bus_e.pend_raw, m_pend[1]);
            chk("E pend_out", bus_e.pend_out, m_pend[1] & m_mask[1]);
            chk("E irq",      {3'b000, bus_e.irq}, {3'b000, |(m_pend[1] & m_mask[1])});
            chk("E ovf",      bus_e.ovf, m_ovf[1]);
            chk("E ack_err",  {3'b000, bus_e.ack_err}, {3'b000, m_err[1]});
            chk("L pend_raw", bus_l.pend_raw, m_pend[0]);
            chk("L pend_out", bus_l.pend_out, m_pend[0] & m_mask[0]);
            chk("L irq",      {3'b000, bus_l.irq}, {3'b000, |(m_pend[0] & m_mask[0])});
            chk("L ovf",      bus_l.ovf, m_ovf[0]);
            chk("L ack_err",  {3'b000, bus_l.ack_err}, {3'b000, m_err[0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_ack(input logic [IDX_W-1:0] idx);
        ack     = 1'b1;
        ack_idx = idx;
        step();
        ack     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_in = '0; mask_wr = 1'b0; mask_din = '0;
        ack = 1'b0; ack_idx = '0; clr_ovf = 1'b0;
        step();
        step();
        checking = 1'b1;
        chk("reset pend_raw", bus_e.pend_raw, 4'b0000);
        chk("reset pend_out", bus_e.pend_out, 4'b0000);
        chk("reset irq",      {3'b000, bus_e.irq}, 4'b0000);
        chk("reset ovf",      bus_e.ovf, 4'b0000);
        rst = 1'b0;

        // One-cycle pulse on bit 2: visible exactly after the third edge.
        req_in = 4'b0100; step();
        req_in = 4'b0000; step();
        chk("pulse early", bus_e.pend_raw, 4'b0000);
        step();
        chk("pulse pend_raw", bus_e.pend_raw, 4'b0100);
        chk("pulse pend_out", bus_e.pend_out, 4'b0100);
        chk("pulse irq",      {3'b000, bus_e.irq}, 4'b0001);
        do_ack(2'd2);
        chk("ack2 pend_raw", bus_e.pend_raw, 4'b0000);
        chk("ack2 irq",      {3'b000, bus_e.irq}, 4'b0000);
        chk("ack2 ack_err",  {3'b000, bus_e.ack_err}, 4'b0000);

        // Held lines capture once; second ack to a cleared bit is an error.
        req_in = 4'b1001;
        step(); step(); step();
        chk("held capture", bus_e.pend_raw, 4'b1001);
        step(); step();
        chk("held single", bus_e.pend_raw, 4'b1001);
        chk("held no ovf", bus_e.ovf, 4'b0000);
        do_ack(2'd0);
        chk("ack0 pend_raw", bus_e.pend_raw, 4'b1000);
        chk("ack0 no err",   {3'b000, bus_e.ack_err}, 4'b0000);
        do_ack(2'd0);
        chk("ack0 again err",  {3'b000, bus_e.ack_err}, 4'b0001);
        chk("ack0 again pend", bus_e.pend_raw, 4'b1000);
        step();
        chk("ack_err one cycle", {3'b000, bus_e.ack_err}, 4'b0000);

        // Masking.
        req_in = 4'b0000;
        step(); step(); step();
        do_ack(2'd3);
        chk("cleared", bus_e.pend_raw, 4'b0000);
        mask_wr = 1'b1; mask_din = 4'b1110; step(); mask_wr = 1'b0;
        req_in = 4'b0001; step();
        req_in = 4'b0000; step(); step();
        chk("masked pend_raw", bus_e.pend_raw, 4'b0001);
        chk("masked pend_out", bus_e.pend_out, 4'b0000);
        chk("masked irq",      {3'b000, bus_e.irq}, 4'b0000);
        mask_wr = 1'b1; mask_din = 4'b1111; step(); mask_wr = 1'b0;
        chk("unmask pend_out", bus_e.pend_out, 4'b0001);
        chk("unmask irq",      {3'b000, bus_e.irq}, 4'b0001);
        do_ack(2'd0);

        // Overflow on bit 3, clear, then event coincident with ack.
        req_in = 4'b1000; step();
        req_in = 4'b0000; step();
        req_in = 4'b1000; step();
        req_in = 4'b0000; step();
        step(); step(); step();
        chk("ovf pend", bus_e.pend_raw, 4'b1000);
        chk("ovf set",  bus_e.ovf, 4'b1000);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        chk("ovf clr", bus_e.ovf, 4'b0000);
        req_in = 4'b1000; step();
        req_in = 4'b0000; step();
        do_ack(2'd3);
        chk("ev+ack pend", bus_e.pend_raw, 4'b1000);
        chk("ev+ack ovf",  bus_e.ovf, 4'b0000);
        chk("ev+ack err",  {3'b000, bus_e.ack_err}, 4'b0000);
        do_ack(2'd3);
        chk("bit3 cleared", bus_e.pend_raw, 4'b0000);

        // Level mode: ack drops the bit for one cycle while the line stays high.
        req_in = 4'b0010;
        step(); step(); step(); step();
        chk("lvl set", {3'b000, bus_l.pend_raw[1]}, 4'b0001);
        do_ack(2'd1);
        chk("lvl acked", {3'b000, bus_l.pend_raw[1]}, 4'b0000);
        step();
        chk("lvl reset",  {3'b000, bus_l.pend_raw[1]}, 4'b0001);
        chk("lvl no ovf", bus_l.ovf, 4'b0000);

        // Reset mid-operation with a line held high.
        rst = 1'b1; step(); rst = 1'b0;
        req_in = 4'b0110; step();
        req_in = 4'b0010; step(); step();
        chk("pre-rst pend", bus_e.pend_raw, 4'b0110);
        rst = 1'b1; step();
        chk("rst pend_raw", bus_e.pend_raw, 4'b0000);
        chk("rst pend_out", bus_e.pend_out, 4'b0000);
        chk("rst irq",      {3'b000, bus_e.irq}, 4'b0000);
        chk("rst ovf",      bus_e.ovf, 4'b0000);
        chk("rst ack_err",  {3'b000, bus_e.ack_err}, 4'b0000);
        rst = 1'b0;
        step(); step();
        chk("post-rst early", bus_e.pend_raw, 4'b0000);
        step();
        chk("post-rst edge", bus_e.pend_raw, 4'b0010);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) req_in[b] = ~req_in[b];
            end
            mask_wr  = ($urandom_range(0, 15) == 0);
            mask_din = 4'($urandom_range(0, 15));
            ack      = ($urandom_range(0, 2) == 0);
            ack_idx  = 2'($urandom_range(0, 3));
            clr_ovf  = ($urandom_range(0, 19) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; ack = 1'b0; mask_wr = 1'b0; clr_ovf = 1'b0; req_in = '0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
